// File: rtl/banked_register_file_pkg.sv
// Shared types and physical-register layout for the banked ARM register file.
package regfile_pkg;

  localparam int unsigned NUM_PHYS = 30;
  localparam int unsigned PHYS_W   = 5;
  localparam int unsigned ARCH_W   = 4;
  localparam int unsigned MODE_W   = 5;

  typedef logic [PHYS_W-1:0] phys_idx_t;

  typedef enum logic [MODE_W-1:0] {
    MODE_USR = 5'b10000,
    MODE_FIQ = 5'b10001,
    MODE_IRQ = 5'b10010,
    MODE_SVC = 5'b10011,
    MODE_ABT = 5'b10111,
    MODE_UND = 5'b11011,
    MODE_SYS = 5'b11111
  } mode_e;

  localparam logic [ARCH_W-1:0] ARCH_PC = 4'd15;

  // First physical slot of each bank (r8-r12 groups, then r13/r14 pairs)
  localparam phys_idx_t HI_USR_BASE   = 5'd8;
  localparam phys_idx_t HI_FIQ_BASE   = 5'd13;
  localparam phys_idx_t SPLR_USR_BASE = 5'd18;
  localparam phys_idx_t SPLR_FIQ_BASE = 5'd20;
  localparam phys_idx_t SPLR_IRQ_BASE = 5'd22;
  localparam phys_idx_t SPLR_SVC_BASE = 5'd24;
  localparam phys_idx_t SPLR_ABT_BASE = 5'd26;
  localparam phys_idx_t SPLR_UND_BASE = 5'd28;

endpackage

// File: rtl/banked_register_file_bank_mapper.sv
// Maps {mode, user-force, architectural address} to a physical register index.
module bank_mapper
  import regfile_pkg::*;
(
  input  logic [MODE_W-1:0] mode_i,
  input  logic              user_i,
  input  logic [ARCH_W-1:0] addr_i,
  output phys_idx_t         phys_o,
  output logic              is_pc_o
);

  logic      is_fiq;
  phys_idx_t splr_base;

  // Unknown mode encodings fall back to the user bank
  always_comb begin
    is_fiq    = 1'b0;
    splr_base = SPLR_USR_BASE;
    if (!user_i) begin
      case (mode_e'(mode_i))
        MODE_FIQ: begin
          is_fiq    = 1'b1;
          splr_base = SPLR_FIQ_BASE;
        end
        MODE_IRQ: splr_base = SPLR_IRQ_BASE;
        MODE_SVC: splr_base = SPLR_SVC_BASE;
        MODE_ABT: splr_base = SPLR_ABT_BASE;
        MODE_UND: splr_base = SPLR_UND_BASE;
        default:  splr_base = SPLR_USR_BASE;
      endcase
    end
  end

  always_comb begin
    is_pc_o = (addr_i == ARCH_PC);
    phys_o  = '0;
    if (addr_i < 4'd8) begin
      phys_o = PHYS_W'(addr_i);
    end else if (addr_i < 4'd13) begin
      phys_o = (is_fiq ? HI_FIQ_BASE : HI_USR_BASE) + PHYS_W'(addr_i - 4'd8);
    end else if (!is_pc_o) begin
      phys_o = splr_base + PHYS_W'(addr_i - 4'd13);
    end
  end

endmodule

// File: rtl/banked_register_file.sv
// Multi-ported banked ARM register file with write bypass and busy scoreboard.
module banked_register_file
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned NUM_RD    = 3,
  parameter int unsigned NUM_WR    = 2,
  parameter bit          BYPASS_EN = 1'b1
) (
  input  logic                            i_clk_w,
  input  logic                            i_rst_w,
  input  logic [MODE_W-1:0]               i_mode_w,
  input  logic [DATA_W-1:0]               i_r15_w,
  input  logic [NUM_RD-1:0][ARCH_W-1:0]   i_rd_addr_w,
  input  logic [NUM_RD-1:0]               i_rd_user_w,
  output logic [NUM_RD-1:0][DATA_W-1:0]   o_rd_data_w,
  output logic [NUM_RD-1:0]               o_rd_busy_w,
  input  logic [NUM_WR-1:0]               i_wr_en_w,
  input  logic [NUM_WR-1:0][ARCH_W-1:0]   i_wr_addr_w,
  input  logic [NUM_WR-1:0]               i_wr_user_w,
  input  logic [NUM_WR-1:0][DATA_W-1:0]   i_wr_data_w,
  input  logic                            i_claim_en_w,
  input  logic [ARCH_W-1:0]               i_claim_addr_w,
  output logic                            o_r15_written_w,
  output logic [DATA_W-1:0]               o_r15_data_w
);

  phys_idx_t         rd_phys [NUM_RD];
  logic [NUM_RD-1:0] rd_pc;
  phys_idx_t         wr_phys [NUM_WR];
  logic [NUM_WR-1:0] wr_pc;
  phys_idx_t         claim_phys;
  logic              claim_pc;

  logic [DATA_W-1:0]   regs_q [NUM_PHYS];
  logic [DATA_W-1:0]   regs_d [NUM_PHYS];
  logic [NUM_PHYS-1:0] busy_q;
  logic [NUM_PHYS-1:0] busy_d;

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd_map
    bank_mapper u_map (
      .mode_i  (i_mode_w),
      .user_i  (i_rd_user_w[g]),
      .addr_i  (i_rd_addr_w[g]),
      .phys_o  (rd_phys[g]),
      .is_pc_o (rd_pc[g])
    );
  end

  for (genvar g = 0; g < NUM_WR; g++) begin : g_wr_map
    bank_mapper u_map (
      .mode_i  (i_mode_w),
      .user_i  (i_wr_user_w[g]),
      .addr_i  (i_wr_addr_w[g]),
      .phys_o  (wr_phys[g]),
      .is_pc_o (wr_pc[g])
    );
  end

  // Claims always use the current mode's bank
  bank_mapper u_claim_map (
    .mode_i  (i_mode_w),
    .user_i  (1'b0),
    .addr_i  (i_claim_addr_w),
    .phys_o  (claim_phys),
    .is_pc_o (claim_pc)
  );

  // Read ports; later write ports override earlier ones on bypass
  always_comb begin
    o_rd_data_w = '0;
    o_rd_busy_w = '0;
    for (int unsigned r = 0; r < NUM_RD; r++) begin
      o_rd_data_w[r] = regs_q[rd_phys[r]];
      o_rd_busy_w[r] = busy_q[rd_phys[r]];
      if (BYPASS_EN && !i_rst_w) begin
        for (int unsigned w = 0; w < NUM_WR; w++) begin
          if (i_wr_en_w[w] && !wr_pc[w] && (wr_phys[w] == rd_phys[r])) begin
            o_rd_data_w[r] = i_wr_data_w[w];
          end
        end
      end
      if (rd_pc[r]) begin
        o_rd_data_w[r] = i_r15_w;
        o_rd_busy_w[r] = 1'b0;
      end
    end
  end

  always_comb begin
    o_r15_written_w = 1'b0;
    o_r15_data_w    = '0;
    for (int unsigned w = 0; w < NUM_WR; w++) begin
      if (i_wr_en_w[w] && wr_pc[w]) begin
        o_r15_written_w = 1'b1;
        o_r15_data_w    = i_wr_data_w[w];
      end
    end
  end

  // Writes clear busy; a same-cycle claim is newer and wins
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int unsigned w = 0; w < NUM_WR; w++) begin
      if (i_wr_en_w[w] && !wr_pc[w]) begin
        regs_d[wr_phys[w]] = i_wr_data_w[w];
        busy_d[wr_phys[w]] = 1'b0;
      end
    end
    if (i_claim_en_w && !claim_pc) begin
      busy_d[claim_phys] = 1'b1;
    end
  end

  always_ff @(posedge i_clk_w or posedge i_rst_w) begin
    if (i_rst_w) begin
      for (int unsigned p = 0; p < NUM_PHYS; p++) begin
        regs_q[p] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: tb/tb_banked_register_file.sv
// Randomised scoreboard bench for banked_register_file against a bank-keyed model.
module tb_banked_register_file;

  localparam int NRD = 3;
  localparam int NWR = 2;
  localparam int DW  = 32;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [4:0]               mode;
  logic [DW-1:0]            r15;
  logic [NRD-1:0][3:0]      rd_addr;
  logic [NRD-1:0]           rd_user;
  logic [NRD-1:0][DW-1:0]   rd_data;
  logic [NRD-1:0]           rd_busy;
  logic [NWR-1:0]           wr_en;
  logic [NWR-1:0][3:0]      wr_addr;
  logic [NWR-1:0]           wr_user;
  logic [NWR-1:0][DW-1:0]   wr_data;
  logic                     claim_en;
  logic [3:0]               claim_addr;
  logic                     r15_wrt;
  logic [DW-1:0]            r15_data;

  banked_register_file #(.DATA_W(DW), .NUM_RD(NRD), .NUM_WR(NWR), .BYPASS_EN(1'b1)) dut (
    .i_clk_w         (clk),
    .i_rst_w         (rst),
    .i_mode_w        (mode),
    .i_r15_w         (r15),
    .i_rd_addr_w     (rd_addr),
    .i_rd_user_w     (rd_user),
    .o_rd_data_w     (rd_data),
    .o_rd_busy_w     (rd_busy),
    .i_wr_en_w       (wr_en),
    .i_wr_addr_w     (wr_addr),
    .i_wr_user_w     (wr_user),
    .i_wr_data_w     (wr_data),
    .i_claim_en_w    (claim_en),
    .i_claim_addr_w  (claim_addr),
    .o_r15_written_w (r15_wrt),
    .o_r15_data_w    (r15_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    string                  tag;
    logic [NRD-1:0][DW-1:0] data;
    logic [NRD-1:0]         busy;
    logic                   wrt;
    logic [DW-1:0]          r15d;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Model storage keyed by (bank, arch addr) rather than physical slot
  logic [DW-1:0] m_reg  [int];
  bit            m_busy [int];

  function automatic int bank_of(input logic [4:0] m, input logic u);
    if (u) return 0;
    case (m)
      5'b10001: return 1;
      5'b10010: return 2;
      5'b10011: return 3;
      5'b10111: return 4;
      5'b11011: return 5;
      default:  return 0;
    endcase
  endfunction

  function automatic int key_of(input logic [4:0] m, input logic u, input logic [3:0] a);
    int b;
    b = bank_of(m, u);
    if (a < 4'd8)  return int'(a);
    if (a < 4'd13) return ((b == 1) ? 100 : 0) + int'(a);
    return b * 100 + int'(a);
  endfunction

  task automatic check(input string name, input int idx, input logic [DW-1:0] got, input logic [DW-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s[%0d] got=%h want=%h at %0t", name, idx, got, want, $time);
    end
  endtask

  // Called at a negedge with inputs already driven; waits for the next negedge
  task automatic issue(input string tag);
    exp_t e;
    int   k;
    if (rst) begin
      m_reg.delete();
      m_busy.delete();
    end
    e.tag  = tag;
    e.wrt  = 1'b0;
    e.r15d = '0;
    for (int r = 0; r < NRD; r++) begin
      if (rd_addr[r] == 4'd15) begin
        e.data[r] = r15;
        e.busy[r] = 1'b0;
      end else begin
        k = key_of(mode, rd_user[r], rd_addr[r]);
        e.data[r] = m_reg.exists(k) ? m_reg[k] : '0;
        e.busy[r] = m_busy.exists(k) ? m_busy[k] : 1'b0;
        if (!rst) begin
          for (int w = 0; w < NWR; w++) begin
            if (wr_en[w] && wr_addr[w] != 4'd15 && key_of(mode, wr_user[w], wr_addr[w]) == k)
              e.data[r] = wr_data[w];
          end
        end
      end
    end
    for (int w = 0; w < NWR; w++) begin
      if (wr_en[w] && wr_addr[w] == 4'd15) begin
        e.wrt  = 1'b1;
        e.r15d = wr_data[w];
      end
    end
    sb.push_back(e);
    if (!rst) begin
      for (int w = 0; w < NWR; w++) begin
        if (wr_en[w] && wr_addr[w] != 4'd15) begin
          k = key_of(mode, wr_user[w], wr_addr[w]);
          m_reg[k]  = wr_data[w];
          m_busy[k] = 1'b0;
        end
      end
      if (claim_en && claim_addr != 4'd15) m_busy[key_of(mode, 1'b0, claim_addr)] = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic clr();
    wr_en    = '0;
    rd_user  = '0;
    wr_user  = '0;
    claim_en = 1'b0;
  endtask

  task automatic set_rd(input int p, input logic [3:0] a, input logic u);
    rd_addr[p] = a;
    rd_user[p] = u;
  endtask

  task automatic set_wr(input int p, input logic [3:0] a, input logic [DW-1:0] d, input logic u);
    wr_en[p]   = 1'b1;
    wr_addr[p] = a;
    wr_data[p] = d;
    wr_user[p] = u;
  endtask

  // Monitor: outputs are combinational, so one expectation per cycle
  initial begin
    exp_t got_e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        got_e = sb.pop_front();
        for (int r = 0; r < NRD; r++) begin
          check({got_e.tag, "_data"}, r, rd_data[r], got_e.data[r]);
          check({got_e.tag, "_busy"}, r, DW'(rd_busy[r]), DW'(got_e.busy[r]));
        end
        check({got_e.tag, "_r15wr"}, 0, DW'(r15_wrt), DW'(got_e.wrt));
        check({got_e.tag, "_r15data"}, 0, r15_data, got_e.r15d);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0] modes [7] = '{5'b10000, 5'b10001, 5'b10010, 5'b10011, 5'b10111, 5'b11011, 5'b11111};
    rst        = 1'b1;
    mode       = 5'b10000;
    r15        = 32'h0000_1008;
    rd_addr    = '0;
    wr_addr    = '0;
    wr_data    = '0;
    claim_addr = '0;
    clr();
    @(negedge clk);
    issue("reset_hold");
    rst = 1'b0;
    for (int a = 0; a < 5; a++) begin
      for (int p = 0; p < NRD; p++) set_rd(p, 4'(a * 3 + p), 1'b0);
      issue("reset_rd");
    end
    set_rd(0, 4'd15, 1'b0);
    issue("r15_rd");

    // SVC vs USR r13 banking, plus user-forced read
    mode = 5'b10011; set_wr(0, 4'd13, 32'hAAAA_0000, 1'b0); issue("svc_wr");
    mode = 5'b10000; set_wr(0, 4'd13, 32'h5555_0000, 1'b0); issue("usr_wr");
    clr(); set_rd(0, 4'd13, 1'b0); issue("usr_r13");
    mode = 5'b10011; issue("svc_r13");
    set_rd(1, 4'd13, 1'b1); issue("svc_r13_user");

    // FIQ r8 banking and shared r7
    clr();
    mode = 5'b10001; set_wr(0, 4'd8, 32'h1234, 1'b0); issue("fiq_wr8");
    mode = 5'b10000; set_wr(0, 4'd8, 32'h9999, 1'b0); issue("usr_wr8");
    clr(); set_rd(0, 4'd8, 1'b0); set_rd(1, 4'd7, 1'b0); issue("usr_r8");
    mode = 5'b10001; set_wr(0, 4'd7, 32'h77, 1'b0); issue("fiq_r8_wr7");
    clr(); mode = 5'b10000; issue("usr_r7");

    // Same-register collision, bypass and r15 write
    set_wr(0, 4'd3, 32'h11, 1'b0); set_wr(1, 4'd3, 32'h22, 1'b0); set_rd(0, 4'd3, 1'b0);
    issue("wr_collide");
    clr(); set_wr(1, 4'd15, 32'h400, 1'b0); issue("r15_wr");
    clr(); set_rd(2, 4'd15, 1'b0); issue("r15_unchanged");

    // Scoreboard claim/write interaction
    mode = 5'b10010; set_rd(0, 4'd4, 1'b0);
    claim_en = 1'b1; claim_addr = 4'd4; issue("claim");
    set_wr(0, 4'd4, 32'h44, 1'b0); issue("claim_wr");
    claim_en = 1'b0; set_wr(1, 4'd4, 32'h45, 1'b0); issue("wr_only");
    clr(); issue("busy_clr");
    claim_en = 1'b1; claim_addr = 4'd15; issue("claim_pc");

    // Mid-cycle asynchronous reset
    clr(); set_wr(0, 4'd2, 32'hFF, 1'b0); claim_en = 1'b1; claim_addr = 4'd5; issue("pre_rst_wr");
    clr(); set_rd(0, 4'd2, 1'b0); set_rd(1, 4'd5, 1'b0); issue("pre_rst_rd");
    rst = 1'b1; issue("rst_mid");
    set_wr(0, 4'd2, 32'h33, 1'b0); set_wr(1, 4'd15, 32'h44, 1'b0);
    claim_en = 1'b1; claim_addr = 4'd2; issue("rst_wr");
    rst = 1'b0; clr(); issue("post_rst");

    // Randomised traffic
    for (int i = 0; i < 500; i++) begin
      rst  = ($urandom_range(0, 79) == 0);
      mode = ($urandom_range(0, 7) == 0) ? 5'($urandom) : modes[$urandom_range(0, 6)];
      r15  = $urandom;
      for (int p = 0; p < NRD; p++) set_rd(p, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) == 0));
      for (int p = 0; p < NWR; p++) begin
        wr_en[p]   = 1'($urandom);
        wr_addr[p] = 4'($urandom_range(0, 15));
        wr_user[p] = 1'($urandom_range(0, 3) == 0);
        wr_data[p] = $urandom;
      end
      claim_en   = 1'($urandom);
      claim_addr = 4'($urandom_range(0, 15));
      issue("rand");
    end
    rst = 1'b0;
    clr();
    repeat (3) @(negedge clk);
    #3;
    check("drain", 0, DW'(sb.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/banked_register_file.md
Name: banked_register_file

Overview:
- Parametrised successor to the single-cycle ARM register file.
- Holds the full ARM physical register set: r0-r14, with FIQ banking of r8-r14 and IRQ/SVC/ABT/UND banking of r13-r14.
- Provides NUM_RD read ports and NUM_WR write ports, optional write-through bypass, and a per-physical-register busy scoreboard for multi-cycle loads.
- Sits between the decode stage (reads), the writeback stage (writes) and the PC logic (r15 is external).

Parameters:
- DATA_W, 32: register width.
- NUM_RD, 3: read ports (Rn, Rm, Rs/Rd-for-store).
- NUM_WR, 2: write ports (ALU result, load data / base writeback).
- BYPASS_EN, 1: 1 = a read of a register written this cycle returns the new data.

Ports:
- i_clk_w, in, 1: clock.
- i_rst_w, in, 1: reset, asynchronous, active-high.
- i_mode_w, in, 5: current CPSR M[4:0].
- i_r15_w, in, DATA_W: PC value returned for reads of r15.
- i_rd_addr_w, in, NUM_RD x 4: architectural read addresses.
- i_rd_user_w, in, NUM_RD: per-port force user bank (LDM/STM ^).
- o_rd_data_w, out, NUM_RD x DATA_W: read data.
- o_rd_busy_w, out, NUM_RD: addressed physical register has a pending claim.
- i_wr_en_w, in, NUM_WR: write enables.
- i_wr_addr_w, in, NUM_WR x 4: write addresses.
- i_wr_user_w, in, NUM_WR: per-port force user bank.
- i_wr_data_w, in, NUM_WR x DATA_W: write data.
- i_claim_en_w, in, 1: mark a destination as pending.
- i_claim_addr_w, in, 4: architectural address to claim (current mode).
- o_r15_written_w, out, 1: some enabled write port targets r15.
- o_r15_data_w, out, DATA_W: data of that r15 write.

Behaviour:
- Storage is 30 physical registers:
  - r0-r7 shared (phys 0-7).
  - r8-r12 user (8-12) and FIQ (13-17).
  - r13/r14 for USR/SYS (18-19), FIQ (20-21), IRQ (22-23), SVC (24-25), ABT (26-27), UND (28-29).
- Mode decode:
  - 10000/11111 = USR/SYS.
  - 10001 = FIQ, 10010 = IRQ, 10011 = SVC, 10111 = ABT, 11011 = UND.
  - Any other encoding maps as USR.
- A user-force bit selects the USR/SYS bank regardless of i_mode_w.
- Reads are combinational, zero latency.
  - Address 15 returns i_r15_w and o_rd_busy_w = 0.
  - Otherwise they return the mapped physical register.
- Bypass (BYPASS_EN = 1): if an enabled write port targets the same physical register this cycle, the read returns that port's i_wr_data_w. Among several matching ports, the highest index wins.
- Bypass disabled (BYPASS_EN = 0): reads return the pre-edge value.
- Writes take effect at posedge i_clk_w; the new value is visible on non-bypass reads the next cycle.
- Two ports writing the same physical register in the same cycle: the highest port index wins.
- The same architectural address in different banks does not collide.
- Writes to address 15 are never stored.
  - o_r15_written_w is combinational and set when any enabled write port has addr 15.
  - o_r15_data_w = data of the highest-index such port, 0 when none.
- Scoreboard: one busy bit per physical register.
  - i_claim_en_w with addr != 15 sets the bit at the next edge, mapped using i_mode_w with no user force.
  - Any enabled write to a physical register clears its bit at the edge.
  - Claim and write to the same physical register in the same cycle: the bit ends set (the claim belongs to the newer instruction).
  - Claim of r15 is ignored.
  - Re-claiming an already-busy register is allowed; the bit stays set.
- o_rd_busy_w reflects the registered busy bit of the mapped register. It is not cleared early by a same-cycle write.
- Mode change takes effect combinationally on the very cycle i_mode_w changes.
- Reset: all physical registers = 0 and all busy bits = 0, asynchronously.
  - Outputs during reset: o_rd_data_w = 0 for non-15 addresses (i_r15_w for 15), o_rd_busy_w = 0.
  - o_r15_written_w and o_r15_data_w still follow the write inputs combinationally.
  - Writes and claims are ignored while i_rst_w is high.

Decomposition:
- Package regfile_pkg holds:
  - mode_e enum (MODE_USR, MODE_FIQ, MODE_IRQ, MODE_SVC, MODE_ABT, MODE_UND, MODE_SYS with the encodings above);
  - localparam NUM_PHYS = 30 and PHYS_W = 5;
  - phys_idx_t typedef;
  - bank base constants.
- Sub-module bank_mapper (combinational) maps {mode, user-force, arch addr} to {phys idx, is_pc}. It is instantiated once per read port, once per write port and once for the claim path.

Test Plan:
- Reset, then read r0-r14 on all ports in USR -> all 0, all busy 0. Read r15 with i_r15_w = 0x0000_1008 -> 0x0000_1008.
- In SVC write r13 = 0xAAAA_0000, switch mode to 10000, write r13 = 0x5555_0000 -> USR r13 reads 0x5555_0000; in SVC mode r13 reads 0xAAAA_0000, and again with i_rd_user_w = 1 reads 0x5555_0000.
- In FIQ write r8 = 0x1234, in USR write r8 = 0x9999 -> FIQ r8 = 0x1234, USR r8 = 0x9999. Write r7 = 0x77 in FIQ -> visible as 0x77 in USR.
- Same cycle: port 0 writes r3 = 0x11, port 1 writes r3 = 0x22, port 0 reads r3 -> bypass read 0x22; next cycle r3 = 0x22. Port 1 writes r15 = 0x400 -> o_r15_written_w = 1, o_r15_data_w = 0x400, r15 storage unchanged.
- Claim r4 in IRQ -> busy on r4 next cycle. Write r4 with claim r4 in the same cycle -> still busy. Write only -> busy 0 next cycle.
- Write r2 = 0xFF, assert i_rst_w mid-cycle -> r2 reads 0 immediately and busy bits clear. Writes during reset leave registers at 0.
